alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Sequencing controller for the 64-bit ALU datapath (A accumulator, Q register, M operand register, shared adder, shared in/out buses). Accepts an operation code and start pulse, then drives the one-hot-style control word `c[10:0]` cycle by cycle to perform add, subtract, Booth radix-2 multiply and restoring divide. It replaces ad-hoc testbench sequencing of the control lines and is the only driver of them in the ALU top level.

## Interface
- `W`, 64, datapath width; iteration count for mul/div; minimum 4
- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  asynchronous active-low reset
- `start`  in  1  begin operation; sampled only in IDLE
- `op`  in  2  00 add, 01 sub, 10 mul, 11 div; latched with `start`
- `q0`  in  1  Q[0] from Q register
- `q_m1`  in  1  Q[-1] (shifted-out bit held by Q register)
- `a_msb`  in  1  A[W-1], sign of partial remainder
- `c`  out  11  control word, bit meanings below
- `busy`  out  1  high from first cycle after accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse in final output cycle
- `err`  out  1  one-cycle pulse on rejected op (see Configuration)

## Operation
- Control bits: c0 clear A and Q[-1]; c1 load Q from inbus; c2 load M from inbus; c3 A <= A + (c4 ? -M : M); c4 subtract select; c5 A drives outbus; c6 Q drives outbus; c7 A shift left, LSB from Q msb; c8 Q shift left; c9 Q[0] <= 1; c10 arithmetic right shift A:Q:Q[-1].
- States: IDLE, LDX, LDY, ADD1, ADD2, TEST, SHR, SHL, DSUB, CHK, OUTA, OUTQ.
- Add/sub: LDX (c0|c2, X on inbus) -> ADD1 (c3) -> LDY (c2, Y on inbus) -> ADD2 (c3, plus c4 if sub) -> OUTA (c5, done) -> IDLE.
- Mul: LDX (c0|c1, multiplier) -> LDY (c2, multiplicand) -> W x [TEST -> SHR] -> OUTA (c5, high word) -> OUTQ (c6, low word, done).
  - TEST: {q0,q_m1}=10 -> c3|c4; 01 -> c3; 00/11 -> c=0. SHR: c10, counter increment.
- Div: LDX (c0|c1, dividend) -> LDY (c2, divisor) -> W x [SHL -> DSUB -> CHK] -> OUTA (c5, remainder) -> OUTQ (c6, quotient, done).
  - SHL: c7|c8. DSUB: c3|c4. CHK: a_msb=0 -> c9; a_msb=1 -> c3 (restore); counter increment.
- Iteration counter `$clog2(W)` bits, cleared in LDX; loop exits after the iteration whose increment makes count reach W (checked on value W-1).
- Divide-by-zero not detected; result is whatever datapath produces (quotient all ones, remainder = dividend).
- `start` while busy ignored, including in the `done` cycle; `op` changes while busy ignored.

## Timing
- State register sequential; `c`, `done`, `busy` combinational decode of state (TEST/CHK also of status inputs). IDLE decodes to all zero.
- Reset: state IDLE, counter 0; `c`=0, `busy`=0, `done`=0, `err`=0. Reset mid-operation aborts immediately, no output cycle.
- `start` high in IDLE at edge N -> LDX active in cycle N+1.
- Cycles from LDX through `done` inclusive: add/sub 5; mul 2W+4; div 3W+4. Back-to-back: next `start` accepted in the IDLE cycle following `done`.
- Status inputs must be valid in the same cycle they are consumed (registered datapath outputs satisfy this).

## Configuration
- `ALU_CTRL_DIV_EN` defined: divide path and states SHL/DSUB/CHK compiled in.
- Not defined: op=11 with `start` -> `err` pulses one cycle, FSM stays IDLE, `c`=0, `busy` stays 0; division states absent.

## Structure
- Package `alu_ctrl_pkg`: state enum, op code constants, control bit index constants (C_CLR_A ... C_SHR_AQ).
- Sub-module `alu_ctrl_cnt`: iteration counter with clear, increment, last-iteration flag.

## Test plan
- Add, W=64: op=00, start -> c = 0x005, 0x008, 0x004, 0x008, 0x020; `done` with last; sub gives 0x018 in ADD2.
- Mul, W=4, q0=1, q_m1=0 tied -> alternating 0x018/0x400 four times, then 0x020, 0x040; `done` at cycle 12.
- Div, W=4, a_msb=0 tied -> repeating 0x180, 0x018, 0x200 four times, then 0x020, 0x040, `done` at cycle 16; a_msb=1 -> CHK gives 0x008.
- Datapath integration, W=64: mul X=-3, Y=5 -> A=0xFFFF_FFFF_FFFF_FFFF, Q=0xFFFF_FFFF_FFFF_FFF1; div 100/7 -> Q=14, A=2.
- `rst_b` low in TEST of mul -> `c`=0, `busy`=0 immediately; new start after release runs full 2W+4.
- `start` pulsed mid-op and in `done` cycle -> ignored; macro off, op=11 -> `err` one cycle, `busy` 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sequencing controller: FSM states, op codes and
// control-word bit positions.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LDX, S_LDY, S_ADD1, S_ADD2, S_TEST,
        S_SHR, S_SHL, S_DSUB, S_CHK, S_OUTA, S_OUTQ
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int C_CLR_A  = 0;
    localparam int C_LD_Q   = 1;
    localparam int C_LD_M   = 2;
    localparam int C_ADD    = 3;
    localparam int C_SUB    = 4;
    localparam int C_OUT_A  = 5;
    localparam int C_OUT_Q  = 6;
    localparam int C_SHL_A  = 7;
    localparam int C_SHL_Q  = 8;
    localparam int C_SET_Q0 = 9;
    localparam int C_SHR_AQ = 10;
    localparam int C_W      = 11;

    typedef logic [C_W-1:0] ctrl_t;

    function automatic ctrl_t cbit(input int idx);
        return ctrl_t'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Handshake, status and control-word bundle between the sequencer and the
// ALU datapath; master is the controller, slave the datapath/requester side.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic       start;
    logic [1:0] op;
    logic       q0;
    logic       q_m1;
    logic       a_msb;
    ctrl_t      c;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, op, q0, q_m1, a_msb,
        output c, busy, done, err
    );

    modport slave (
        output start, op, q0, q_m1, a_msb,
        input  c, busy, done, err
    );
endinterface

// File: rtl/alu_ctrl_cnt.sv
// Mul/div iteration counter: cleared at operand load, stepped once per
// iteration, flags the last iteration while holding W-1.
module alu_ctrl_cnt #(
    parameter int W = 64
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last_o = (cnt_q == CW'(W - 1));
endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller for the ALU datapath (add, sub, Booth mul, restoring div).
// Divide support is compiled in only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    alu_ctrl_if.master  bus
);
    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;
    logic       last;

    alu_ctrl_cnt #(.W(W)) u_cnt (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr_i  (state_q == S_LDX),
        .inc_i  ((state_q == S_SHR) || (state_q == S_CHK)),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // The op code is captured only on an accepted start; later changes are ignored.
    assign op_d = (state_q == S_IDLE && bus.start) ? bus.op : op_q;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef ALU_CTRL_DIV_EN
                    state_d = S_LDX;
`else
                    if (bus.op == OP_DIV)
                        err_d = 1'b1;
                    else
                        state_d = S_LDX;
`endif
                end
            end
            S_LDX:  state_d = op_q[1] ? S_LDY : S_ADD1;
            S_ADD1: state_d = S_LDY;
            S_LDY: begin
                if (!op_q[1])
                    state_d = S_ADD2;
`ifdef ALU_CTRL_DIV_EN
                else if (op_q == OP_DIV)
                    state_d = S_SHL;
`endif
                else
                    state_d = S_TEST;
            end
            S_ADD2: state_d = S_OUTA;
            S_TEST: state_d = S_SHR;
            S_SHR:  state_d = last ? S_OUTA : S_TEST;
`ifdef ALU_CTRL_DIV_EN
            S_SHL:  state_d = S_DSUB;
            S_DSUB: state_d = S_CHK;
            S_CHK:  state_d = last ? S_OUTA : S_SHL;
`endif
            S_OUTA: state_d = op_q[1] ? S_OUTQ : S_IDLE;
            S_OUTQ: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.c    = '0;
        bus.done = 1'b0;
        bus.busy = (state_q != S_IDLE);
        case (state_q)
            S_LDX:  bus.c = cbit(C_CLR_A) | (op_q[1] ? cbit(C_LD_Q) : cbit(C_LD_M));
            S_ADD1: bus.c = cbit(C_ADD);
            S_LDY:  bus.c = cbit(C_LD_M);
            S_ADD2: bus.c = cbit(C_ADD) | ((op_q == OP_SUB) ? cbit(C_SUB) : '0);
            S_TEST: begin
                // Booth recoding: 10 subtracts M, 01 adds M, 00/11 only shift.
                case ({bus.q0, bus.q_m1})
                    2'b10:   bus.c = cbit(C_ADD) | cbit(C_SUB);
                    2'b01:   bus.c = cbit(C_ADD);
                    default: bus.c = '0;
                endcase
            end
            S_SHR:  bus.c = cbit(C_SHR_AQ);
            S_SHL:  bus.c = cbit(C_SHL_A) | cbit(C_SHL_Q);
            S_DSUB: bus.c = cbit(C_ADD) | cbit(C_SUB);
            // Negative partial remainder means the trial subtract failed: add M back.
            S_CHK:  bus.c = bus.a_msb ? cbit(C_ADD) : cbit(C_SET_Q0);
            S_OUTA: begin
                bus.c    = cbit(C_OUT_A);
                bus.done = !op_q[1];
            end
            S_OUTQ: begin
                bus.c    = cbit(C_OUT_Q);
                bus.done = 1'b1;
            end
            default: bus.c = '0;
        endcase
    end

    assign bus.err = err_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl: cycle-exact control-word tables on a W=4 instance,
// plus a behavioural datapath closed around a W=64 instance.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    alu_ctrl_if bus4();
    alu_ctrl_if bus64();

    alu_ctrl #(.W(4))  dut4  (.clk(clk), .rst_b(rst_b), .bus(bus4.master));
    alu_ctrl #(.W(64)) dut64 (.clk(clk), .rst_b(rst_b), .bus(bus64.master));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural datapath for the W=64 instance.
    logic [63:0] dp_a, dp_q, dp_m, x_val, y_val, inbus, outbus;
    logic        dp_qm;

    assign inbus       = bus64.c[C_CLR_A] ? x_val : y_val;
    assign outbus      = bus64.c[C_OUT_A] ? dp_a : (bus64.c[C_OUT_Q] ? dp_q : 64'd0);
    assign bus64.q0    = dp_q[0];
    assign bus64.q_m1  = dp_qm;
    assign bus64.a_msb = dp_a[63];

    function automatic logic [128:0] dp_next(input logic [63:0] a_i, input logic [63:0] q_i,
                                             input logic qm_i, input logic [63:0] m_i,
                                             input ctrl_t c_i, input logic [63:0] in_i);
        logic [63:0] a, q;
        logic        qm;
        a = a_i; q = q_i; qm = qm_i;
        if (c_i[C_CLR_A])  begin a = '0; qm = 1'b0; end
        if (c_i[C_LD_Q])   q = in_i;
        if (c_i[C_ADD])    a = c_i[C_SUB] ? a - m_i : a + m_i;
        if (c_i[C_SHL_A])  a = {a[62:0], q[63]};
        if (c_i[C_SHL_Q])  q = {q[62:0], 1'b0};
        if (c_i[C_SET_Q0]) q[0] = 1'b1;
        if (c_i[C_SHR_AQ]) {a, q, qm} = {a[63], a, q};
        return {a, q, qm};
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dp_a <= '0; dp_q <= '0; dp_qm <= 1'b0; dp_m <= '0;
        end else begin
            {dp_a, dp_q, dp_qm} <= dp_next(dp_a, dp_q, dp_qm, dp_m, bus64.c, inbus);
            if (bus64.c[C_LD_M]) dp_m <= inbus;
        end
    end

    // Flat table of expected {done, c} per cycle, indexed by scenario records.
    typedef struct {
        string      name;
        logic [1:0] op;
        logic       q0, q_m1, a_msb;
        bit         poke;
        int         first;
        int         len;
    } scen_t;

    logic [11:0] exp_q[$];
    scen_t       scen[$];

    task automatic e(input logic [10:0] c, input bit d);
        exp_q.push_back({d, c});
    endtask

    task automatic run_seq(input scen_t s);
        logic [11:0] ex;
        @(negedge clk);
        bus4.op = s.op; bus4.q0 = s.q0; bus4.q_m1 = s.q_m1; bus4.a_msb = s.a_msb;
        bus4.start = 1'b1;
        for (int i = 0; i < s.len; i++) begin
            @(negedge clk);
            bus4.start = s.poke && (i == 2 || i == s.len - 1);
            if (s.poke) bus4.op = ~s.op;
            ex = exp_q[s.first + i];
            check($sformatf("%s[%0d] c", s.name, i), 64'(bus4.c), 64'(ex[10:0]));
            check($sformatf("%s[%0d] busy", s.name, i), 64'(bus4.busy), 64'd1);
            check($sformatf("%s[%0d] done", s.name, i), 64'(bus4.done), 64'(ex[11]));
        end
        @(negedge clk);
        bus4.start = 1'b0;
        check({s.name, " idle c"}, 64'(bus4.c), 64'd0);
        check({s.name, " idle busy"}, 64'(bus4.busy), 64'd0);
        check({s.name, " idle err"}, 64'(bus4.err), 64'd0);
    endtask

    task automatic run64(input string name, input logic [1:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp_hi,
                         input logic [63:0] exp_lo, input int exp_len);
        logic [63:0] hi, lo;
        int          n;
        bit          got;
        hi = '0; lo = '0; n = 0; got = 1'b0;
        x_val = x; y_val = y;
        @(negedge clk);
        bus64.op = op; bus64.start = 1'b1;
        @(negedge clk);
        bus64.start = 1'b0;
        while (!got && n < 400) begin
            n++;
            if (bus64.c[C_OUT_A]) hi = outbus;
            if (bus64.c[C_OUT_Q]) lo = outbus;
            if (bus64.done) got = 1'b1;
            else @(negedge clk);
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " cycles"}, 64'(n), 64'(exp_len));
        check({name, " high/A"}, hi, exp_hi);
        check({name, " low/Q"}, lo, exp_lo);
        @(negedge clk);
        check({name, " idle busy"}, 64'(bus64.busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t s;

        s = '{name: "add", op: OP_ADD, q0: 0, q_m1: 0, a_msb: 0, poke: 0, first: 0, len: 0};
        s.first = exp_q.size();
        e(11'h005, 0); e(11'h008, 0); e(11'h004, 0); e(11'h008, 0); e(11'h020, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

        s.name = "sub"; s.op = OP_SUB; s.first = exp_q.size();
        e(11'h005, 0); e(11'h008, 0); e(11'h004, 0); e(11'h018, 0); e(11'h020, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

        s.name = "mul10"; s.op = OP_MUL; s.q0 = 1; s.q_m1 = 0; s.first = exp_q.size();
        e(11'h003, 0); e(11'h004, 0);
        for (int i = 0; i < 4; i++) begin e(11'h018, 0); e(11'h400, 0); end
        e(11'h020, 0); e(11'h040, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

        s.name = "mul01_poke"; s.q0 = 0; s.q_m1 = 1; s.poke = 1; s.first = exp_q.size();
        e(11'h003, 0); e(11'h004, 0);
        for (int i = 0; i < 4; i++) begin e(11'h008, 0); e(11'h400, 0); end
        e(11'h020, 0); e(11'h040, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

        s.name = "mul11"; s.q0 = 1; s.q_m1 = 1; s.poke = 0; s.first = exp_q.size();
        e(11'h003, 0); e(11'h004, 0);
        for (int i = 0; i < 4; i++) begin e(11'h000, 0); e(11'h400, 0); end
        e(11'h020, 0); e(11'h040, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

`ifdef ALU_CTRL_DIV_EN
        s.name = "div_pos"; s.op = OP_DIV; s.q0 = 0; s.q_m1 = 0; s.a_msb = 0; s.first = exp_q.size();
        e(11'h003, 0); e(11'h004, 0);
        for (int i = 0; i < 4; i++) begin e(11'h180, 0); e(11'h018, 0); e(11'h200, 0); end
        e(11'h020, 0); e(11'h040, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);

        s.name = "div_neg"; s.a_msb = 1; s.poke = 1; s.first = exp_q.size();
        e(11'h003, 0); e(11'h004, 0);
        for (int i = 0; i < 4; i++) begin e(11'h180, 0); e(11'h018, 0); e(11'h008, 0); end
        e(11'h020, 0); e(11'h040, 1);
        s.len = exp_q.size() - s.first; scen.push_back(s);
`endif

        bus4.start = 1'b0; bus4.op = OP_ADD; bus4.q0 = 0; bus4.q_m1 = 0; bus4.a_msb = 0;
        bus64.start = 1'b0; bus64.op = OP_ADD;
        x_val = '0; y_val = '0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("reset c", 64'(bus4.c), 64'd0);
        check("reset busy", 64'(bus4.busy), 64'd0);
        check("reset done", 64'(bus4.done), 64'd0);
        check("reset err", 64'(bus4.err), 64'd0);
        check("reset c64", 64'(bus64.c), 64'd0);
        rst_b = 1'b1;

        for (int k = 0; k < scen.size(); k++) run_seq(scen[k]);

        // Reset in the first TEST cycle of a multiply aborts at once.
        @(negedge clk);
        bus4.op = OP_MUL; bus4.q0 = 1; bus4.q_m1 = 0; bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset TEST c", 64'(bus4.c), 64'h018);
        rst_b = 1'b0;
        #1;
        check("mid-op reset c", 64'(bus4.c), 64'd0);
        check("mid-op reset busy", 64'(bus4.busy), 64'd0);
        check("mid-op reset done", 64'(bus4.done), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        run_seq(scen[2]);

`ifndef ALU_CTRL_DIV_EN
        // Divide disabled: op=11 is rejected with a one-cycle err pulse.
        @(negedge clk);
        bus4.op = OP_DIV; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("div reject err", 64'(bus4.err), 64'd1);
        check("div reject busy", 64'(bus4.busy), 64'd0);
        check("div reject c", 64'(bus4.c), 64'd0);
        @(negedge clk);
        check("div reject err pulse", 64'(bus4.err), 64'd0);
        check("div reject busy after", 64'(bus4.busy), 64'd0);
`endif

        run64("add64", OP_ADD, 64'd100, 64'd23, 64'd123, 64'd0, 5);
        run64("sub64", OP_SUB, 64'd5, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 5);
        run64("mul64", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 132);
`ifdef ALU_CTRL_DIV_EN
        run64("div64", OP_DIV, 64'd100, 64'd7, 64'd2, 64'd14, 196);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
